// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg: shared widths and block type for the AES stream path.
package aes_stream_pkg;
    localparam int AES_BLOCK_WIDTH = 128;
    localparam int AXIS_WORD_WIDTH = 32;
    typedef logic [AES_BLOCK_WIDTH-1:0] aes_block_t;
endpackage

// File: rtl/block_out_reg.sv
// block_out_reg: output block register with valid/ready handshake.
module block_out_reg #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         partial_i,
    input  logic         tready_i,
    output logic [W-1:0] data_o,
    output logic         tvalid_o,
    output logic         last_o,
    output logic         partial_o,
    output logic         empty_o,
    output logic         drain_o
);
    logic [W-1:0] data_q;
    logic         valid_q, valid_d, last_q, partial_q;

    always_comb begin
        drain_o = valid_q && tready_i;
        empty_o = !valid_q;
        valid_d = load_i || (valid_q && !tready_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            partial_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (load_i) begin
                data_q    <= data_i;
                last_q    <= last_i;
                partial_q <= partial_i;
            end
        end
    end

    assign data_o    = data_q;
    assign tvalid_o  = valid_q;
    assign last_o    = last_q;
    assign partial_o = partial_q;
endmodule

// File: rtl/axis_block_packer.sv
// axis_block_packer: packs 32-bit AXI-Stream beats big-endian into 128-bit blocks,
// zero-padding short packets; one completed block can wait behind the output register.
module axis_block_packer
    import aes_stream_pkg::*;
#(
    parameter int IN_WIDTH  = AXIS_WORD_WIDTH,
    parameter int OUT_WIDTH = AES_BLOCK_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [OUT_WIDTH-1:0] write_data,
    output logic                 write_tvalid,
    input  logic                 write_tready,
    output logic                 write_last,
    output logic                 write_partial
);
    localparam int WORDS = OUT_WIDTH / IN_WIDTH;
    localparam int CW    = WORDS > 1 ? $clog2(WORDS) : 1;

    logic [OUT_WIDTH-1:0] asm_data_q, asm_data_d, merged, ld_data;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 asm_full_q, asm_full_d, asm_last_q, asm_last_d, asm_partial_q, asm_partial_d;
    logic                 accept, last_word, complete, can_load, load, ld_last, ld_partial;
    logic                 out_empty, out_drain;

    always_comb begin
        accept        = s_axis_tvalid && !asm_full_q;
        last_word     = cnt_q == CW'(WORDS - 1);
        complete      = accept && (last_word || s_axis_tlast);
        // Words past cnt are still zero, so OR-ing in the new beat also zero-pads.
        merged        = (cnt_q == '0 ? '0 : asm_data_q)
                      | (OUT_WIDTH'(s_axis_tdata) << (IN_WIDTH * (WORDS - 1 - int'(cnt_q))));
        can_load      = out_empty || out_drain;
        load          = asm_full_q ? out_drain : (complete && can_load);
        ld_data       = asm_full_q ? asm_data_q : merged;
        ld_last       = asm_full_q ? asm_last_q : s_axis_tlast;
        ld_partial    = asm_full_q ? asm_partial_q : (s_axis_tlast && !last_word);
        asm_full_d    = asm_full_q ? !out_drain : (complete && !can_load);
        asm_data_d    = accept ? merged : asm_data_q;
        asm_last_d    = complete ? s_axis_tlast : asm_last_q;
        asm_partial_d = complete ? (s_axis_tlast && !last_word) : asm_partial_q;
        cnt_d         = complete ? '0 : (accept ? cnt_q + CW'(1) : cnt_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_data_q    <= '0;
            cnt_q         <= '0;
            asm_full_q    <= 1'b0;
            asm_last_q    <= 1'b0;
            asm_partial_q <= 1'b0;
        end else begin
            asm_data_q    <= asm_data_d;
            cnt_q         <= cnt_d;
            asm_full_q    <= asm_full_d;
            asm_last_q    <= asm_last_d;
            asm_partial_q <= asm_partial_d;
        end
    end

    assign s_axis_tready = !asm_full_q;

    block_out_reg #(.W(OUT_WIDTH)) u_out (
        .clk       (clk),
        .rst_n     (reset_n),
        .load_i    (load),
        .data_i    (ld_data),
        .last_i    (ld_last),
        .partial_i (ld_partial),
        .tready_i  (write_tready),
        .data_o    (write_data),
        .tvalid_o  (write_tvalid),
        .last_o    (write_last),
        .partial_o (write_partial),
        .empty_o   (out_empty),
        .drain_o   (out_drain)
    );
endmodule

// File: tb/tb_axis_block_packer.sv
// tb_axis_block_packer: directed and randomized checks of axis_block_packer against a
// packet-level scoreboard that chunks accepted beats into expected blocks.
module tb_axis_block_packer;
    logic         clk = 1'b0, reset_n = 1'b1;
    logic [31:0]  s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, write_tready = 1'b0;
    logic         s_axis_tready, write_tvalid, write_last, write_partial;
    logic [127:0] write_data;

    typedef struct {
        logic [127:0] d;
        logic         l;
        logic         p;
    } exp_t;

    exp_t         q[$];
    logic [31:0]  words[4];
    int           n = 0, tests = 0, fails = 0, n_out = 0, acc = 0;
    bit           prev_stall = 1'b0;
    logic [129:0] prev_out = '0;

    axis_block_packer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .write_data    (write_data),
        .write_tvalid  (write_tvalid),
        .write_tready  (write_tready),
        .write_last    (write_last),
        .write_partial (write_partial)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: accepted beats fill words[] in arrival order; a block closes at 4 words or tlast.
    task automatic model_beat(input logic [31:0] d, input logic l);
        exp_t e;
        words[n] = d;
        n++;
        if (n == 4 || l) begin
            e.d = '0;
            for (int k = 0; k < n; k++) e.d[127-32*k -: 32] = words[k];
            e.l = l;
            e.p = l && (n != 4);
            q.push_back(e);
            n = 0;
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] d, input logic l, input logic r, output bit took);
        @(negedge clk);
        if (prev_stall) begin
            chk("hold_valid", 130'(write_tvalid), 130'(1));
            chk("hold_data", {write_last, write_partial, write_data}, prev_out);
        end
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        write_tready  = r;
        #1;
        if (write_tvalid && write_tready) begin
            n_out++;
            chk("sb_nonempty", 130'(q.size() != 0), 130'(1));
            if (q.size() != 0) begin
                exp_t e = q.pop_front();
                chk("blk_data", 130'(write_data), 130'(e.d));
                chk("blk_last", 130'(write_last), 130'(e.l));
                chk("blk_partial", 130'(write_partial), 130'(e.p));
            end
        end
        took = v && s_axis_tready;
        if (took) begin
            model_beat(d, l);
            acc++;
        end
        prev_stall = write_tvalid && !write_tready;
        prev_out   = {write_last, write_partial, write_data};
    endtask

    task automatic drain(input int max);
        bit t;
        for (int k = 0; k < max && (q.size() != 0 || write_tvalid); k++) cycle(1'b0, '0, 1'b0, 1'b1, t);
        chk("drained", 130'(q.size()), 130'(0));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tready"}, 130'(s_axis_tready), 130'(1));
        chk({tag, "_tvalid"}, 130'(write_tvalid), 130'(0));
        chk({tag, "_data"}, 130'(write_data), 130'(0));
        chk({tag, "_last"}, 130'(write_last), 130'(0));
        chk({tag, "_partial"}, 130'(write_partial), 130'(0));
    endtask

    initial begin
        bit t;
        int i, acc0, o0, blocks, plen, pidx;
        logic [31:0] cur;
        logic v, r;
        #2 reset_n = 1'b0;
        #1 chk_reset("rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Full 4-beat packet, visible exactly one cycle
        cycle(1, 32'h00112233, 0, 1, t);
        cycle(1, 32'h44556677, 0, 1, t);
        cycle(1, 32'h8899AABB, 0, 1, t);
        cycle(1, 32'hCCDDEEFF, 1, 1, t);
        cycle(0, '0, 0, 1, t);
        chk("t1_valid", 130'(write_tvalid), 130'(1));
        chk("t1_data", 130'(write_data), 130'(128'h00112233_44556677_8899AABB_CCDDEEFF));
        chk("t1_last", 130'(write_last), 130'(1));
        chk("t1_partial", 130'(write_partial), 130'(0));
        cycle(0, '0, 0, 1, t);
        chk("t1_once", 130'(write_tvalid), 130'(0));

        // Short packet, zero-padded
        cycle(1, 32'hDEADBEEF, 0, 1, t);
        cycle(1, 32'h01234567, 1, 1, t);
        cycle(0, '0, 0, 1, t);
        chk("t2_data", 130'(write_data), 130'(128'hDEADBEEF_01234567_00000000_00000000));
        chk("t2_last", 130'(write_last), 130'(1));
        chk("t2_partial", 130'(write_partial), 130'(1));
        for (int k = 0; k < 4; k++) cycle(1, 32'hC0DE0000 + k, k == 3, 1, t);
        drain(10);

        // Stalled output: 8 beats absorbed, then back-pressure
        acc0 = acc;
        i = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(1, 32'hA0000000 + i, 0, 0, t);
            if (t) i++;
        end
        chk("t3_accepted", 130'(acc - acc0), 130'(8));
        chk("t3_tready", 130'(s_axis_tready), 130'(0));
        chk("t3_held", 130'(write_data), 130'(128'hA0000000_A0000001_A0000002_A0000003));
        o0 = n_out;
        for (int k = 0; k < 40 && (i < 12 || q.size() != 0 || write_tvalid); k++) begin
            cycle(i < 12, 32'hA0000000 + i, 0, 1, t);
            if (t) i++;
        end
        chk("t3_blocks", 130'(n_out - o0), 130'(3));
        chk("t3_empty", 130'(q.size()), 130'(0));

        // Continuous input with ready toggling 1 in 2
        acc0 = acc;
        for (int k = 0; k < 24; k++) cycle(1, $urandom, 0, k % 2 == 1, t);
        chk("t4_no_stall", 130'(acc - acc0), 130'(24));
        drain(20);

        // Reset mid-packet
        cycle(1, 32'h11111111, 0, 1, t);
        cycle(1, 32'h22222222, 0, 1, t);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk_reset("t5_rst");
        n = 0;
        q.delete();
        prev_stall = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        o0 = n_out;
        for (int k = 0; k < 4; k++) cycle(1, 32'hB0000000 + k, k == 3, 1, t);
        drain(10);
        chk("t5_one_block", 130'(n_out - o0), 130'(1));

        // Randomized packets of 1-4 beats with random valid/ready
        blocks = 0;
        pidx = 0;
        plen = $urandom_range(1, 4);
        cur = $urandom;
        o0 = n_out;
        while (blocks < 11000) begin
            v = ($urandom % 4) != 0;
            r = ($urandom % 4) != 0;
            cycle(v, cur, pidx == plen - 1, r, t);
            if (t) begin
                cur = $urandom;
                pidx++;
                if (pidx == plen) begin
                    blocks++;
                    pidx = 0;
                    plen = $urandom_range(1, 4);
                end
            end
        end
        drain(50);
        chk("t6_blocks", 130'(n_out - o0), 130'(11000));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axis_block_packer.md
# axis_block_packer

Upstream stage of the async FIFO write port. Gathers 32-bit AXI-Stream beats from the DMA-side interface into 128-bit AES blocks and presents them on a valid/ready write interface matching the FIFO's `write_tvalid`/`write_tready`/`write_data`. Short packets are zero-padded to a full block and flagged. A full block and a second block in assembly can coexist, so input throughput is one beat per cycle while the output drains.

## Interface
- `IN_WIDTH`, 32, input beat width.
- `OUT_WIDTH`, 128, output block width; must be an integer multiple of `IN_WIDTH`.
- `WORDS`, derived as `OUT_WIDTH/IN_WIDTH` (4); not overridable.

- `clk` in 1: single clock; the block has one clock, and reset is asynchronous and active-low.
- `reset_n` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in IN_WIDTH: input beat.
- `s_axis_tvalid` in 1: input beat valid.
- `s_axis_tready` out 1: block accepts a beat.
- `s_axis_tlast` in 1: last beat of packet.
- `write_data` out OUT_WIDTH: assembled block, to the FIFO write port.
- `write_tvalid` out 1: block valid.
- `write_tready` in 1: FIFO accepts the block.
- `write_last` out 1: block ends a packet.
- `write_partial` out 1: block was zero-padded (packet ended before `WORDS` beats).

## Operation
- Assembly register `asm_data`, beat counter `cnt` [log2(WORDS)-1:0], and flag `asm_full`.
- Output register holds `write_data`, `write_last`, `write_partial`, `write_tvalid`.
- Beat acceptance: a beat is accepted when `s_axis_tvalid && s_axis_tready`.
- Beat placement: the first beat of a block goes to bits [OUT_WIDTH-1:OUT_WIDTH-IN_WIDTH] (big-endian, matching the AES core byte order). Beat k goes to bits [OUT_WIDTH-1-k*IN_WIDTH -: IN_WIDTH].
- Block completion: a block completes on an accepted beat with `cnt==WORDS-1` or with `s_axis_tlast=1`. Unfilled words are 0. `partial = tlast && cnt!=WORDS-1`. `last = tlast`.
- Moving a completed block to output:
  - If the output register is empty, or drains this cycle (`write_tvalid && write_tready`), the block loads into the output register on the same edge.
  - Otherwise it stays in `asm_data` with `asm_full=1`.
- While `asm_full=1`:
  - `s_axis_tready=0`.
  - On the edge where the output drains, `asm_data` moves to output, `asm_full` clears, and `cnt` returns to 0.
- `cnt` wraps to 0 after each completed block. It is never left nonzero after tlast.
- `s_axis_tready` is driven by a register (`!asm_full`). There is no combinational path from `write_tready`.
- `write_tvalid` stays high until the handshake, and `write_data`/`write_last`/`write_partial` stay stable while `write_tvalid && !write_tready`.
- Reset mid-packet: the partial block and any held block are discarded and no output is produced for them.

## Timing
- Reset values: `s_axis_tready=1`, `write_tvalid=0`, `write_data=0`, `write_last=0`, `write_partial=0`, `cnt=0`, `asm_full=0`.
- Latency: `write_tvalid` rises on the edge that accepts the completing beat, so the block is visible the cycle after that beat.
- Sustained throughput: 1 beat/cycle in and 1 block per `WORDS` cycles out, provided `write_tready` is high at least once every `WORDS` cycles.
- Simultaneous events:
  - Completing beat plus output drain on the same edge: the new block replaces the old one, with no bubble.
  - Drain while `asm_full`: transfer happens on that edge, and `s_axis_tready` rises the following cycle.
- Back-pressure: if the output is stalled indefinitely, exactly one extra full block is absorbed before `s_axis_tready` falls.

## Structure
- Shared package `aes_stream_pkg`: `AES_BLOCK_WIDTH=128`, `AXIS_WORD_WIDTH=32`, typedef `aes_block_t` (logic [127:0]).
- The block is a single module. An optional sub-module `block_out_reg` holds the output register and handshake: load/hold/drain, exposing `empty` and `drain` to the packer FSM.

## Test plan
- Four beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF (tlast on the 4th), with `write_tready=1`:
  - `write_data`=0x00112233_44556677_8899AABB_CCDDEEFF, `write_last=1`, `write_partial=0`.
  - `write_tvalid` is high for exactly 1 cycle, the cycle after beat 4.
- Two beats 0xDEADBEEF, 0x01234567 with tlast on the 2nd:
  - `write_data`=0xDEADBEEF_01234567_00000000_00000000, `write_last=1`, `write_partial=1`, `cnt` back to 0.
- `write_tready=0` with 12 beats offered continuously:
  - Exactly 8 beats are accepted, then `s_axis_tready=0`, and the first block is held stable.
  - On releasing `write_tready`, blocks 1, 2, 3 emerge in order with no loss or duplication.
- Continuous 1-beat/cycle input with `write_tready` toggling 1 in 2: no input stall, and `write_tvalid` never drops before its handshake.
- Assert `reset_n=0` after 2 beats of a packet:
  - All outputs take their reset values immediately.
  - A fresh 4-beat packet after release produces only that block.
- Randomized 11000 blocks of random length 1–4 with random valid/ready, against a scoreboard queue: all blocks match and the pass message is printed.
